// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 width/sign codes for loads and stores
//   - FSM state enum used by load_store_unit
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational data path of the load/store unit.
//   we, funct3, addr_lo : request kind, width code, byte offset in word
//   wdata               : right-aligned store data
//   rdata               : word read from RAM
//   load_data           : byte/half/word extracted and sign/zero extended
//   store_data          : word to write (merged lane for SB/SH, wdata for SW)
//   err                 : illegal funct3 or misaligned access
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        illegal;
  logic        misaligned;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    load_data = '0;
    case (funct3)
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data = {24'd0, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data = {16'd0, half_sel};
      LW:      load_data = rdata;
      default: load_data = '0;
    endcase

    store_data = rdata;
    case (funct3[1:0])
      2'b00: store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (addr_lo[1]) store_data[31:16] = wdata[15:0];
        else            store_data[15:0]  = wdata[15:0];
      end
      default: store_data = wdata;
    endcase

    // Stores have no unsigned variants, so funct3[2] set on a store is illegal too.
    illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (we && funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    err        = illegal || misaligned;
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit in front of a word-wide synchronous RAM.
//   clk, rst              : clock, asynchronous active-high reset
//   req_*                 : CPU request (valid/ready handshake, we, funct3, addr, wdata)
//   resp_valid/rdata/err  : one-cycle completion pulse with load result / error flag
//   mem_ren/raddr/rdata   : RAM read port, rdata valid one cycle after ren
//   mem_wen/waddr/wdata   : RAM write port
// Sub-word stores are read-modify-write: RD -> WAIT (merge) -> WR -> RESP.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter  int unsigned MEM_DEPTH  = 256,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata
);

  lsu_state_t            state;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;

  logic                  a_we;
  logic [2:0]            a_f3;
  logic [1:0]            a_lo;
  logic [31:0]           a_wdata;
  logic [31:0]           load_data;
  logic [31:0]           store_data;
  logic                  a_err;

  logic [ADDR_WIDTH-1:0] req_word;
  logic                  unused_addr_hi;

  // Upper address bits wrap around the RAM.
  assign req_word       = req_addr[ADDR_WIDTH+1:2];
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  // The single align instance checks the live request in IDLE and works on
  // the latched request in every other state.
  always_comb begin
    if (state == IDLE) begin
      a_we    = req_we;
      a_f3    = req_funct3;
      a_lo    = req_addr[1:0];
      a_wdata = req_wdata;
    end else begin
      a_we    = we_q;
      a_f3    = f3_q;
      a_lo    = addr_q[1:0];
      a_wdata = wdata_q;
    end
  end

  lsu_align u_align (
    .we         (a_we),
    .funct3     (a_f3),
    .addr_lo    (a_lo),
    .wdata      (a_wdata),
    .rdata      (mem_rdata),
    .load_data  (load_data),
    .store_data (store_data),
    .err        (a_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_ren    <= 1'b0;
      mem_raddr  <= '0;
      mem_wen    <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            addr_q    <= req_addr[ADDR_WIDTH+1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (a_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && (req_funct3 == SW)) begin
              state     <= WR;
              mem_wen   <= 1'b1;
              mem_waddr <= req_word;
              mem_wdata <= req_wdata;
            end else begin
              state     <= RD;
              mem_ren   <= 1'b1;
              mem_raddr <= req_word;
            end
          end
        end
        RD: begin
          mem_ren <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (we_q) begin
            state     <= WR;
            mem_wen   <= 1'b1;
            mem_waddr <= addr_q[ADDR_WIDTH+1:2];
            mem_wdata <= store_data;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        WR: begin
          mem_wen    <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          mem_ren    <= 1'b0;
          mem_wen    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random requests against a byte-level
// reference model; a simple synchronous RAM model sits on the memory ports.
module tb_load_store_unit;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata = '0;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] got_rdata, got_wdata, got_waddr, got_lat, got_wen_cyc;
  logic        got_err;

  load_store_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= ram[mem_raddr];
    if (mem_wen) ram[mem_waddr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and compare everything it causes against the model.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    int unsigned size, off, idx, lat, wen_cyc;
    int unsigned ren_cnt, wen_cnt, both, resp_cyc;
    logic        bad;
    logic [31:0] w, v, exp_rdata, new_w, ren_addr, wen_addr, wen_data, r_data;
    logic        r_err;

    size = 32'd1 << f3[1:0];
    off  = a % 4;
    idx  = (a / 4) % DEPTH;
    bad  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4) ||
           ((off % size) != 0);
    w         = ref_mem[idx];
    new_w     = w;
    exp_rdata = last_rdata;
    wen_cyc   = 0;
    if (bad) begin
      lat       = 1;
      exp_rdata = '0;
    end else if (we) begin
      for (int unsigned i = 0; i < size; i++) begin
        new_w = (new_w & ~(32'hFF << (8 * (off + i)))) |
                (((wd >> (8 * i)) & 32'hFF) << (8 * (off + i)));
      end
      lat     = (size == 4) ? 2 : 4;
      wen_cyc = (size == 4) ? 1 : 3;
    end else begin
      v = w >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v >= 32'd128) v = v + 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      exp_rdata = v;
      lat       = 3;
    end

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    ren_cnt = 0; wen_cnt = 0; both = 0; resp_cyc = 0;
    ren_addr = '0; wen_addr = '0; wen_data = '0; r_data = '0; r_err = 1'b0;
    got_wen_cyc = '0;
    for (int unsigned cyc = 1; cyc <= 12; cyc++) begin
      if (mem_ren && mem_wen) both++;
      if (mem_ren) begin ren_cnt++; ren_addr = {28'd0, mem_raddr}; end
      if (mem_wen) begin
        wen_cnt++; wen_addr = {28'd0, mem_waddr}; wen_data = mem_wdata; got_wen_cyc = cyc;
      end
      if (resp_valid) begin
        resp_cyc = cyc; r_data = resp_rdata; r_err = resp_err;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    chk("wen_idle", {31'd0, mem_wen}, 32'd0);

    chk("latency", resp_cyc, lat);
    chk("resp_err", {31'd0, r_err}, {31'd0, bad});
    chk("resp_rdata", r_data, exp_rdata);
    chk("ren_wen_overlap", both, 0);
    chk("ren_count", ren_cnt, (!bad && !(we && size == 4)) ? 1 : 0);
    if (ren_cnt != 0) chk("raddr", ren_addr, idx);
    chk("wen_count", wen_cnt, (!bad && we) ? 1 : 0);
    if (wen_cnt != 0) begin
      chk("wen_cycle", got_wen_cyc, wen_cyc);
      chk("waddr", wen_addr, idx);
      chk("wdata", wen_data, new_w);
    end

    if (!bad && we) ref_mem[idx] = new_w;
    last_rdata = exp_rdata;
    chk("ram_word", ram[idx], ref_mem[idx]);

    got_rdata = r_data;
    got_err   = r_err;
    got_wdata = wen_data;
    got_waddr = wen_addr;
    got_lat   = resp_cyc;
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] orig;

    last_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_held", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    #2 rst = 1'b0;
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_ren", {31'd0, mem_ren}, 32'd0);
    chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // Fill RAM through the unit; the first request follows reset release directly.
    for (int unsigned i = 0; i < DEPTH; i++) do_req(1'b1, 3'b010, i * 4, $urandom);

    // SW then LW of the same word.
    do_req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    chk("sw8_wen_cycle", got_wen_cyc, 32'd1);
    chk("sw8_waddr", got_waddr, 32'd2);
    chk("sw8_lat", got_lat, 32'd2);
    do_req(1'b0, 3'b010, 32'h8, 32'h0);
    chk("lw8_data", got_rdata, 32'hDEADBEEF);
    chk("lw8_lat", got_lat, 32'd3);
    chk("lw8_err", {31'd0, got_err}, 32'd0);

    // Sub-word loads.
    do_req(1'b0, 3'b000, 32'h9, 32'h0); chk("lb9", got_rdata, 32'hFFFFFFBE);
    do_req(1'b0, 3'b100, 32'h9, 32'h0); chk("lbu9", got_rdata, 32'h000000BE);
    do_req(1'b0, 3'b001, 32'hA, 32'h0); chk("lha", got_rdata, 32'hFFFFDEAD);
    do_req(1'b0, 3'b101, 32'hA, 32'h0); chk("lhua", got_rdata, 32'h0000DEAD);

    // Sub-word stores.
    do_req(1'b1, 3'b000, 32'hB, 32'h12);
    chk("sbb_wdata", got_wdata, 32'h12ADBEEF);
    chk("sbb_lat", got_lat, 32'd4);
    chk("sbb_rdata_kept", got_rdata, 32'h0000DEAD);
    do_req(1'b1, 3'b001, 32'h8, 32'h5678);
    chk("sh8_wdata", got_wdata, 32'h12AD5678);
    chk("sh8_lat", got_lat, 32'd4);

    // Errors.
    do_req(1'b0, 3'b010, 32'h6, 32'h0);
    chk("lw6_err", {31'd0, got_err}, 32'd1); chk("lw6_rdata", got_rdata, 32'd0);
    chk("lw6_lat", got_lat, 32'd1);
    do_req(1'b1, 3'b001, 32'h3, 32'hFFFF);
    chk("sh3_err", {31'd0, got_err}, 32'd1); chk("sh3_lat", got_lat, 32'd1);
    do_req(1'b0, 3'b011, 32'h10, 32'h0);
    chk("f3_011_err", {31'd0, got_err}, 32'd1); chk("f3_011_rdata", got_rdata, 32'd0);

    // Reset while an SB sits in WAIT: the store must be abandoned.
    orig = ref_mem[1];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h4; req_wdata = ~orig;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_rd_ren", {31'd0, mem_ren}, 32'd1);
    @(posedge clk);
    #1;
    chk("abort_wait_wen", {31'd0, mem_wen}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort_rst_wen", {31'd0, mem_wen}, 32'd0);
    chk("abort_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("abort_hold_wen", {31'd0, mem_wen}, 32'd0);
    end
    #2 rst = 1'b0;
    last_rdata = '0;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_resp_rdata", resp_rdata, 32'd0);
    chk("abort_ram", ram[1], orig);
    do_req(1'b0, 3'b010, 32'h4, 32'h0);
    chk("abort_lw", got_rdata, orig);

    // Random mix, full 32-bit addresses to exercise wrap.
    for (int unsigned n = 0; n < 200; n++) begin
      we = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      if (we && ($urandom % 4) != 0) f3 = 3'($urandom % 3);
      do_req(we, f3, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, RAM depth in 32-bit words; localparam ADDR_WIDTH = $clog2(MEM_DEPTH).
REQ-002 SHALL have ports, one clock, asynchronous active-high reset:
  clk  input  1  rising-edge clock
  rst  input  1  asynchronous, active-high reset
  req_valid  input  1  CPU memory request present
  req_ready  output  1  unit can accept request
  req_we  input  1  1=store, 0=load
  req_funct3  input  3  RV32I width/sign code
  req_addr  input  32  byte address
  req_wdata  input  32  store data, right-aligned
  resp_valid  output  1  one-cycle completion pulse
  resp_rdata  output  32  load result, extended
  resp_err  output  1  misaligned or illegal funct3
  mem_ren  output  1  RAM read enable
  mem_raddr  output  ADDR_WIDTH  RAM word read address
  mem_rdata  input  32  RAM read data, valid one cycle after mem_ren
  mem_wen  output  1  RAM write enable
  mem_waddr  output  ADDR_WIDTH  RAM word write address
  mem_wdata  output  32  RAM write word

Function
REQ-003 SHALL use word address = req_addr[ADDR_WIDTH+1:2]; higher address bits ignored (wrap).
REQ-004 SHALL implement FSM states IDLE, RD, WAIT, WR, RESP; req_ready=1 only in IDLE.
REQ-005 SHALL latch we, funct3, addr, wdata on req_valid&&req_ready; request held until RESP exits.
REQ-006 From IDLE on accept: error -> RESP; SW -> WR; loads, SB, SH -> RD.
REQ-007 RD: mem_ren=1, mem_raddr=latched word address; next state WAIT.
REQ-008 WAIT: load -> register extracted result into resp_rdata, go RESP; SB/SH -> register merged word, go WR.
REQ-009 WR: mem_wen=1 for exactly one cycle, mem_waddr=latched word address, mem_wdata=merged word (SB/SH) or req_wdata (SW); next RESP.
REQ-010 RESP: resp_valid=1 for exactly one cycle, then IDLE; no response backpressure.
REQ-011 Latency, accept cycle = 0: SW resp at cycle 2; loads resp at cycle 3; SB/SH resp at cycle 4; errors resp at cycle 1.
REQ-012 Load extraction: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes word.
REQ-013 SB merge replaces byte lane addr[1:0] with wdata[7:0]; SH replaces half lane addr[1] with wdata[15:0]; other lanes keep mem_rdata.
REQ-014 Error: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, funct3 in {011,110,111}; no mem_ren/mem_wen issued; resp_err=1, resp_rdata=0.
REQ-015 resp_err=0 and resp_rdata unchanged on successful stores.
REQ-016 mem_ren and mem_wen SHALL never be asserted in the same cycle; mem_ren, mem_wen, resp_valid 0 outside their states.

Reset
REQ-017 rst SHALL force IDLE asynchronously; resp_valid=0, resp_err=0, resp_rdata=0, mem_ren=0, mem_wen=0, req_ready=1 after release.
REQ-018 Reset during RD/WAIT SHALL abort the store; no mem_wen pulse results and RAM word is unchanged.
REQ-019 First request SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-020 Package lsu_pkg SHALL hold funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state enum typedef.
REQ-021 Sub-module lsu_align (combinational) SHALL perform load extraction, store merge and misalignment detection; load_store_unit instantiates it once.

Verification
REQ-022 SW addr 0x8 data 0xDEADBEEF then LW addr 0x8 -> mem_wen at cycle 1, waddr 2; load resp_rdata 0xDEADBEEF at cycle 3, err 0.
REQ-023 Word 2 = 0xDEADBEEF; LB addr 0x9 -> 0xFFFFFFBE; LBU addr 0x9 -> 0x000000BE; LH addr 0xA -> 0xFFFFDEAD; LHU -> 0x0000DEAD.
REQ-024 Word 2 = 0xDEADBEEF; SB addr 0xB data 0x12 -> mem_wdata 0x12ADBEEF; SH addr 0x8 data 0x5678 -> 0x12AD5678; resp at cycle 4.
REQ-025 LW addr 0x6, SH addr 0x3, funct3 011 -> resp_err=1, resp_rdata 0 at cycle 1; no mem_ren/mem_wen observed.
REQ-026 SB addr 0x4 accepted, rst pulsed in WAIT -> no mem_wen, word 1 unchanged, req_ready=1 after release, next LW returns original value.
